bus_timer: RTL and testbench
============================

// Module: bus_timer
// PURPOSE
//  Memory-mapped 16-bit interval timer that acts as a responder on the cpu_6502 bus.
//  It decodes phi2/rw/addr/data like bus_ram and raises an active-low interrupt request
//  for the CPU's i_irq_n. The top level muxes o_data onto the CPU read bus when o_cs=1.
// PARAMETERS
//  BASE_ADDR       16'hD000  8-byte register window; decoded on i_addr[15:3]==BASE_ADDR[15:3]
//  RESET_PRESCALE  8'h00     reset value of the PRESCALE register
// PORTS
//  i_clk     in   1   system clock; same clock that drives cpu_6502
//  i_reset   in   1   asynchronous active-high reset
//  i_phi2    in   1   CPU phi2, synchronous to i_clk
//  i_rw      in   1   1=read, 0=write
//  i_addr    in   16  bus address
//  i_data    in   8   CPU write data
//  o_data    out  8   read data; valid while o_cs & i_rw, 8'h00 otherwise
//  o_cs      out  1   combinational address-window hit
//  o_irq_n   out  1   registered interrupt request, active low
// BEHAVIOUR
//  Bus strobe:
//  - phi2_q is i_phi2 delayed by 1 i_clk; strobe = phi2_q & ~i_phi2 (phi2 falling edge).
//  - A write (o_cs & ~i_rw & strobe) commits at that i_clk edge. Exactly one commit per bus cycle.
//  - Reads are combinational from current state. Reads have no side effects except SNAPSHOT (see CONFIGURATION).
//  Register map (offset = i_addr[2:0]):
//  - 0 CNT_LO:   R counter[7:0];  W latch[7:0]
//  - 1 CNT_HI:   R counter[15:8]. W latch[15:8], then counter<={i_data,latch[7:0]}, IF<=0,
//    prescaler<=0.
//  - 2 CTRL:     bit0 EN, bit1 CONT (auto-reload), bit2 IE. Bits 7:3 read 0, write ignored.
//  - 3 STAT:     bit0 IF (underflow). Write 1 to bit0 clears IF; write 0 has no effect.
//  - 4 PRESCALE: tick every PRESCALE+1 i_clk cycles.
//  - 5-7:        read 8'h00, writes ignored.
//  Reset values:
//  - counter=0, latch=0, CTRL=0, IF=0, PRESCALE=RESET_PRESCALE, prescaler=0, phi2_q=0.
//  - o_irq_n=1.
//  Prescaler and tick:
//  - 8-bit prescaler counts only while EN=1.
//  - At prescaler==PRESCALE: tick=1 and prescaler<=0; otherwise prescaler+1.
//  - EN=0 holds prescaler and counter.
//  Counter on tick:
//  - counter!=0: counter-1.
//  - counter==0: IF<=1 (underflow). Then CONT=1 -> counter<=latch. CONT=0 -> counter stays 0, EN<=0.
//  - Latch=0 with CONT=1: IF sets on every tick.
//  - Counter never wraps to 16'hFFFF.
//  Interrupt:
//  - o_irq_n <= ~(IF & IE), registered.
//  - IRQ asserts 1 cycle after IF sets, or 1 cycle after a write sets IE with IF already 1.
//  Simultaneous events (same i_clk edge):
//  - CNT_HI write vs tick: the write wins and the tick is discarded.
//  - STAT clear vs underflow: set wins, IF=1.
//  - CTRL write clearing EN vs tick: the tick is discarded.
//  - CTRL write vs underflow auto-clear of EN: the CTRL write value wins.
//  Reset mid-operation:
//  - All state returns to reset values immediately (async). o_irq_n deasserts without waiting for a clock.
//  - A bus write in flight is dropped.
// CONFIGURATION
//  BUS_TIMER_SNAPSHOT_EN defined:
//  - A strobe-qualified read of CNT_LO copies counter[15:8] into snap_hi.
//  - CNT_HI reads return snap_hi, giving a coherent LO-then-HI 16-bit read.
//  - snap_hi resets to 0.
//  BUS_TIMER_SNAPSHOT_EN undefined:
//  - CNT_HI reads return live counter[15:8]. No snapshot register exists.
// TESTING
//  - Reset: assert i_reset mid-count -> o_irq_n=1, all registers read 0, PRESCALE=RESET_PRESCALE.
//  - One-shot: PRESCALE=0, latch=16'h0003, CTRL=8'h05 -> counter reads 3,2,1,0 on successive
//    clocks; IF=1 and o_irq_n=0 on the next tick; EN reads 0.
//  - Auto-reload: latch=16'h0002, PRESCALE=8'h03, CTRL=8'h03 -> IF sets every 12 i_clk cycles;
//    counter reloads to 2.
//  - Clear race: write STAT=8'h01 on the same edge as an underflow -> IF stays 1; a later write
//    with no underflow -> IF=0 and o_irq_n=1 one cycle later.
//  - Decode: write 8'hAA to BASE_ADDR+5 and to BASE_ADDR+8 -> no register changes; o_cs=0 at +8;
//    +5 reads 8'h00.
//  - Snapshot (BUS_TIMER_SNAPSHOT_EN): counter=16'h0100 running. Read LO (8'h00), then HI after
//    the decrement to 16'h00FF -> HI reads 8'h01. Without the macro, HI reads 8'h00.

Source files
------------

// File: rtl/bus_timer.sv
// Memory-mapped 16-bit interval timer on the cpu_6502 bus with an active-low IRQ.
// Optional feature: define BUS_TIMER_SNAPSHOT_EN for a coherent LO-then-HI counter read.
module bus_timer #(
  parameter logic [15:0] BASE_ADDR      = 16'hD000,
  parameter logic [7:0]  RESET_PRESCALE = 8'h00
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_phi2,
  input  logic        i_rw,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_data,
  output logic [7:0]  o_data,
  output logic        o_cs,
  output logic        o_irq_n
);

  localparam logic [2:0] OFF_CNT_LO   = 3'd0;
  localparam logic [2:0] OFF_CNT_HI   = 3'd1;
  localparam logic [2:0] OFF_CTRL     = 3'd2;
  localparam logic [2:0] OFF_STAT     = 3'd3;
  localparam logic [2:0] OFF_PRESCALE = 3'd4;

  logic        phi2_q;
  logic [15:0] counter;
  logic [15:0] latch;
  logic        en;
  logic        cont;
  logic        ie;
  logic        irq_flag;
  logic        irq_n_q;
  logic [7:0]  prescale;
  logic [7:0]  prescaler;
  logic [7:0]  hi_rd;
  logic [7:0]  rd_data;

  logic [2:0]  offset;
  logic        strobe;
  logic        wr;
  logic        wr_lo, wr_hi, wr_ctrl, wr_stat, wr_pre;
  logic        tick;
  logic        tick_ok;
  logic        underflow;

  assign o_cs    = (i_addr[15:3] == BASE_ADDR[15:3]);
  assign offset  = i_addr[2:0];
  // One strobe per bus cycle: the i_clk edge right after phi2 falls.
  assign strobe  = phi2_q & ~i_phi2;
  assign wr      = o_cs & ~i_rw & strobe;
  assign wr_lo   = wr & (offset == OFF_CNT_LO);
  assign wr_hi   = wr & (offset == OFF_CNT_HI);
  assign wr_ctrl = wr & (offset == OFF_CTRL);
  assign wr_stat = wr & (offset == OFF_STAT);
  assign wr_pre  = wr & (offset == OFF_PRESCALE);

  assign tick      = en & (prescaler == prescale);
  // A CNT_HI load or a CTRL write that stops the timer swallows a coincident tick.
  assign tick_ok   = tick & ~wr_hi & ~(wr_ctrl & ~i_data[0]);
  assign underflow = tick_ok & (counter == 16'h0000);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      phi2_q    <= 1'b0;
      counter   <= 16'h0000;
      latch     <= 16'h0000;
      en        <= 1'b0;
      cont      <= 1'b0;
      ie        <= 1'b0;
      irq_flag  <= 1'b0;
      irq_n_q   <= 1'b1;
      prescale  <= RESET_PRESCALE;
      prescaler <= 8'h00;
    end else begin
      phi2_q <= i_phi2;

      if (wr_lo)  latch[7:0] <= i_data;
      if (wr_pre) prescale   <= i_data;

      if (wr_hi)   prescaler <= 8'h00;
      else if (en) prescaler <= tick ? 8'h00 : prescaler + 8'd1;

      if (wr_hi) begin
        latch[15:8] <= i_data;
        counter     <= {i_data, latch[7:0]};
      end else if (tick_ok) begin
        if (counter != 16'h0000) counter <= counter - 16'd1;
        else if (cont)           counter <= latch;
      end

      // A CTRL write overrides the one-shot auto-clear of EN.
      if (wr_ctrl)                {ie, cont, en} <= i_data[2:0];
      else if (underflow && !cont) en            <= 1'b0;

      if (underflow)                 irq_flag <= 1'b1;
      else if (wr_hi)                irq_flag <= 1'b0;
      else if (wr_stat && i_data[0]) irq_flag <= 1'b0;

      irq_n_q <= ~(irq_flag & ie);
    end
  end

`ifdef BUS_TIMER_SNAPSHOT_EN
  logic [7:0] snap_hi;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      snap_hi <= 8'h00;
    else if (o_cs && i_rw && strobe && (offset == OFF_CNT_LO))
      snap_hi <= counter[15:8];
  end

  assign hi_rd = snap_hi;
`else
  assign hi_rd = counter[15:8];
`endif

  always_comb begin
    rd_data = 8'h00;
    case (offset)
      OFF_CNT_LO:   rd_data = counter[7:0];
      OFF_CNT_HI:   rd_data = hi_rd;
      OFF_CTRL:     rd_data = {5'b00000, ie, cont, en};
      OFF_STAT:     rd_data = {7'b0000000, irq_flag};
      OFF_PRESCALE: rd_data = prescale;
      default:      rd_data = 8'h00;
    endcase
  end

  assign o_data  = (o_cs & i_rw) ? rd_data : 8'h00;
  assign o_irq_n = irq_n_q;

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: drivers queue expected values, a monitor pops and compares.
// Expected CNT_HI-after-snapshot value follows BUS_TIMER_SNAPSHOT_EN.
module tb_bus_timer;

  localparam logic [15:0] B      = 16'hD000;
  localparam logic [1:0]  K_DATA = 2'd0;
  localparam logic [1:0]  K_IRQ  = 2'd1;
  localparam logic [1:0]  K_CS   = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        phi2;
  logic        rw;
  logic [15:0] addr;
  logic [7:0]  data;
  logic [7:0]  o_data;
  logic        o_cs;
  logic        o_irq_n;

  logic [7:0]  exp_q[$];
  logic [1:0]  kind_q[$];
  string       name_q[$];
  logic        mon_valid = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_hi_snap;

  bus_timer #(.BASE_ADDR(16'hD000), .RESET_PRESCALE(8'h07)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_phi2  (phi2),
    .i_rw    (rw),
    .i_addr  (addr),
    .i_data  (data),
    .o_data  (o_data),
    .o_cs    (o_cs),
    .o_irq_n (o_irq_n)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish (actual running, required done)");
    $fatal(1);
  end

  // monitor: samples 2 time units after each falling edge while a read is presented
  logic [7:0] m_exp;
  logic [7:0] m_act;
  logic [1:0] m_kind;
  string      m_name;

  always @(negedge clk) begin
    #2;
    if (mon_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_empty: actual no entry, required one");
      end else begin
        m_exp  = exp_q.pop_front();
        m_kind = kind_q.pop_front();
        m_name = name_q.pop_front();
        case (m_kind)
          K_IRQ:   m_act = {7'b0, o_irq_n};
          K_CS:    m_act = {7'b0, o_cs};
          default: m_act = o_data;
        endcase
        if (m_act !== m_exp) begin
          n_err++;
          $display("FAIL %s: actual %02h required %02h (t=%0t)", m_name, m_act, m_exp, $time);
        end
      end
    end
  end

  // driver tasks: each starts and ends on a falling edge
  task automatic check(input logic [1:0] kind, input logic [15:0] a, input logic [7:0] e,
                       input string nm);
    addr = a;
    rw   = 1'b1;
    phi2 = 1'b0;
    exp_q.push_back(e);
    kind_q.push_back(kind);
    name_q.push_back(nm);
    mon_valid = 1'b1;
    #3;
    mon_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [2:0] off, input logic [7:0] e, input string nm);
    check(K_DATA, B + 16'(off), e, nm);
  endtask

  task automatic irq(input logic e, input string nm);
    check(K_IRQ, B, {7'b0, e}, nm);
  endtask

  // write commits on the rising edge just before the task returns
  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    addr = B + 16'(off);
    data = d;
    rw   = 1'b0;
    phi2 = 1'b1;
    @(negedge clk);
    phi2 = 1'b0;
    @(negedge clk);
    rw   = 1'b1;
  endtask

  task automatic wr_abs(input logic [15:0] a, input logic [7:0] d);
    addr = a;
    data = d;
    rw   = 1'b0;
    phi2 = 1'b1;
    @(negedge clk);
    phi2 = 1'b0;
    @(negedge clk);
    rw   = 1'b1;
  endtask

  // strobed read: value sampled is the pre-strobe state
  task automatic rd_strobed(input logic [2:0] off, input logic [7:0] e, input string nm);
    addr = B + 16'(off);
    rw   = 1'b1;
    phi2 = 1'b1;
    @(negedge clk);
    check(K_DATA, B + 16'(off), e, nm);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
`ifdef BUS_TIMER_SNAPSHOT_EN
    exp_hi_snap = 8'h01;
`else
    exp_hi_snap = 8'h00;
`endif
    rst = 1'b1; phi2 = 1'b0; rw = 1'b1; addr = 16'h0000; data = 8'h00;
    idle(3);
    rst = 1'b0;

    // reset state
    rd(3'd0, 8'h00, "rst_cnt_lo");
    rd(3'd1, 8'h00, "rst_cnt_hi");
    rd(3'd2, 8'h00, "rst_ctrl");
    rd(3'd3, 8'h00, "rst_stat");
    rd(3'd4, 8'h07, "rst_prescale");
    irq(1'b1, "rst_irq_n");

    // one-shot: counts 3,2,1,0 then underflows and stops
    wr(3'd4, 8'h00);
    wr(3'd0, 8'h03);
    wr(3'd1, 8'h00);
    wr(3'd2, 8'h05);
    rd(3'd0, 8'h03, "os_cnt3");
    rd(3'd0, 8'h02, "os_cnt2");
    rd(3'd0, 8'h01, "os_cnt1");
    rd(3'd0, 8'h00, "os_cnt0");
    rd(3'd3, 8'h01, "os_if_set");
    irq(1'b0, "os_irq_asserted");
    rd(3'd2, 8'h04, "os_en_cleared");
    rd(3'd0, 8'h00, "os_cnt_stays0");
    rd(3'd1, 8'h00, "os_cnt_hi");

    // clear IF; IRQ releases one cycle later
    wr(3'd3, 8'h01);
    irq(1'b0, "clr_irq_still_low");
    irq(1'b1, "clr_irq_released");
    rd(3'd3, 8'h00, "clr_if");

    // auto-reload: latch=2, prescale=3 -> underflow every 12 clocks
    wr(3'd0, 8'h02);
    wr(3'd1, 8'h00);
    wr(3'd4, 8'h03);
    wr(3'd2, 8'h03);
    rd(3'd0, 8'h02, "ar_k0");
    rd(3'd4, 8'h03, "ar_prescale");
    rd(3'd0, 8'h02, "ar_k2");
    rd(3'd0, 8'h02, "ar_k3");
    rd(3'd0, 8'h01, "ar_k4");
    idle(6);
    rd(3'd3, 8'h00, "ar_if_k11");
    rd(3'd3, 8'h01, "ar_if_k12");
    rd(3'd0, 8'h02, "ar_reload");
    irq(1'b1, "ar_irq_masked");
    rd(3'd0, 8'h02, "ar_k15");
    rd(3'd0, 8'h01, "ar_k16");
    wr(3'd3, 8'h00);
    rd(3'd3, 8'h01, "stat_w0_noeffect");
    idle(2);
    wr(3'd3, 8'h01);
    rd(3'd3, 8'h01, "race_set_wins");
    rd(3'd0, 8'h02, "race_reload");
    wr(3'd3, 8'h01);
    rd(3'd3, 8'h00, "late_clear");
    idle(8);
    rd(3'd3, 8'h01, "ar_if_k36");
    wr(3'd2, 8'h07);
    irq(1'b1, "ie_irq_k40");
    irq(1'b0, "ie_irq_k41");
    wr(3'd2, 8'h00);
    rd(3'd0, 8'h01, "ctrl_stop_tick_dropped");
    irq(1'b1, "ie_off_irq");
    idle(4);
    rd(3'd0, 8'h01, "stopped_hold");

    // address decode
    wr_abs(16'hD005, 8'hAA);
    wr_abs(16'hD008, 8'hAA);
    check(K_DATA, 16'hD005, 8'h00, "rd_unmapped5");
    check(K_CS,   16'hD005, 8'h01, "cs_d005");
    check(K_CS,   16'hD008, 8'h00, "cs_d008");
    check(K_DATA, 16'hD008, 8'h00, "data_d008");
    check(K_CS,   16'hCFFF, 8'h00, "cs_cfff");
    wr(3'd1, 8'h00);
    rd(3'd0, 8'h02, "dec_latch_lo");
    rd(3'd3, 8'h00, "dec_if_cleared");
    rd(3'd4, 8'h03, "dec_prescale");
    wr(3'd2, 8'hF8);
    rd(3'd2, 8'h00, "ctrl_upper_ignored");

    // CNT_HI write coinciding with a tick
    wr(3'd4, 8'h00);
    wr(3'd0, 8'h00);
    wr(3'd2, 8'h03);
    idle(3);
    wr(3'd1, 8'h01);
    rd(3'd0, 8'h00, "hi_wr_wins");
    rd(3'd3, 8'h00, "hi_wr_clears_if");
    rd(3'd0, 8'hFE, "hi_wr_then_count");
    rd(3'd1, 8'h00, "hi_live");

    // snapshot read
    wr(3'd4, 8'h03);
    wr(3'd1, 8'h01);
    rd_strobed(3'd0, 8'h00, "snap_lo");
    idle(2);
    rd(3'd1, exp_hi_snap, "snap_hi");
    rd(3'd0, 8'hFF, "snap_lo_after");

    // reset mid-operation with IRQ asserted and a write in flight
    wr(3'd0, 8'h00);
    wr(3'd1, 8'h00);
    wr(3'd2, 8'h07);
    idle(4);
    irq(1'b0, "pre_rst_irq");
    addr = B + 16'd4; data = 8'h55; rw = 1'b0; phi2 = 1'b1;
    @(negedge clk);
    phi2 = 1'b0;
    rst  = 1'b1;
    irq(1'b1, "rst_async_irq");
    rd(3'd0, 8'h00, "rst2_cnt_lo");
    rd(3'd1, 8'h00, "rst2_cnt_hi");
    rd(3'd2, 8'h00, "rst2_ctrl");
    rd(3'd3, 8'h00, "rst2_stat");
    rd(3'd4, 8'h07, "rst2_prescale");
    rst = 1'b0;
    idle(2);
    rd(3'd4, 8'h07, "post_rst_prescale");
    rd(3'd0, 8'h00, "post_rst_cnt");
    irq(1'b1, "post_rst_irq");

    idle(2);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_leftover: actual %0d entries, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
